// File: rtl/hdmi_period_scheduler.sv
// HDMI link-period sequencer: decides per pixel whether the TMDS lanes carry control,
// video (preamble, guard, pixels) or a data island (preamble, guards, 32-cycle packets).
module hdmi_period_scheduler #(
  parameter int BIT_WIDTH   = 10,
  parameter int BIT_HEIGHT  = 10,
  parameter int DI_START_X  = 10,
  parameter int MAX_PACKETS = 18,
  parameter int DVI_OUTPUT  = 0
) (
  input  logic                  pxl_clk,
  input  logic                  rst_n,
  input  logic [BIT_WIDTH-1:0]  cx,
  input  logic [BIT_HEIGHT-1:0] cy,
  input  logic [BIT_WIDTH-1:0]  screen_start_x,
  input  logic [BIT_HEIGHT-1:0] screen_start_y,
  input  logic                  hsync,
  input  logic                  vsync,
  input  logic                  pkt_valid,
  output logic                  pkt_ack,
  output logic [2:0]            mode,
  output logic [5:0]            control_data,
  output logic [4:0]            di_cycle,
  output logic [4:0]            pkt_index
);

  localparam logic [2:0] S_CTRL      = 3'd0;
  localparam logic [2:0] S_VPRE      = 3'd1;
  localparam logic [2:0] S_VGB       = 3'd2;
  localparam logic [2:0] S_VIDEO     = 3'd3;
  localparam logic [2:0] S_DPRE      = 3'd4;
  localparam logic [2:0] S_DGB_LEAD  = 3'd5;
  localparam logic [2:0] S_DDATA     = 3'd6;
  localparam logic [2:0] S_DGB_TRAIL = 3'd7;

  // Comparisons are done in a widened domain so ssx-10 never underflows.
  localparam int EW = BIT_WIDTH + 7;
  localparam logic [EW-1:0] DI_E = EW'(DI_START_X);

  logic [EW-1:0] cx_e, ssx_e;
  logic          at_vp, at_di, active_line, pkt_fits, first_fits;

  assign cx_e        = {7'd0, cx};
  assign ssx_e       = {7'd0, screen_start_x};
  assign at_vp       = (cx_e + EW'(10)) == ssx_e;
  assign at_di       = cx_e == DI_E;
  assign active_line = cy >= screen_start_y;
  // A packet starting at p fits iff p + 38 <= ssx - 10.
  assign pkt_fits    = (cx_e + EW'(48)) <= ssx_e;
  assign first_fits  = (DI_E + EW'(58)) <= ssx_e;

  logic [2:0] state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [4:0] idx_q, idx_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 5'd1;
    idx_d   = idx_q;
    case (state_q)
      S_CTRL: begin
        cnt_d = 5'd0;
        idx_d = 5'd0;
        if (at_vp && active_line)                  state_d = S_VPRE;
        else if (at_di && pkt_valid && first_fits) state_d = S_DPRE;
      end
      S_VPRE: if (cnt_q == 5'd7) begin state_d = S_VGB; cnt_d = 5'd0; end
      S_VGB:  if (cnt_q == 5'd1) begin state_d = S_VIDEO; cnt_d = 5'd0; end
      S_VIDEO: begin
        cnt_d = 5'd0;
        if (cx < screen_start_x) state_d = S_CTRL;
      end
      S_DPRE:     if (cnt_q == 5'd7) begin state_d = S_DGB_LEAD; cnt_d = 5'd0; end
      S_DGB_LEAD: if (cnt_q == 5'd1) begin state_d = S_DDATA; cnt_d = 5'd0; end
      S_DDATA: begin
        if (cnt_q == 5'd31) begin
          cnt_d = 5'd0;
          if (pkt_valid && (idx_q < 5'(MAX_PACKETS - 1)) && pkt_fits) idx_d = idx_q + 5'd1;
          else state_d = S_DGB_TRAIL;
        end
      end
      S_DGB_TRAIL: begin
        if (cnt_q == 5'd1) begin
          state_d = S_CTRL;
          cnt_d   = 5'd0;
          idx_d   = 5'd0;
        end
      end
      default: state_d = S_CTRL;
    endcase
    // Plain DVI has no preambles, so video is simply the active area.
    if (DVI_OUTPUT != 0) begin
      state_d = (cx >= screen_start_x && active_line) ? S_VIDEO : S_CTRL;
      cnt_d   = 5'd0;
      idx_d   = 5'd0;
    end
  end

  logic [2:0] mode_d;
  logic [3:0] ctl_d;

  always_comb begin
    mode_d = 3'd0;
    ctl_d  = 4'd0;
    case (state_d)
      S_VPRE:                   ctl_d  = 4'b0001;
      S_VGB:                    mode_d = 3'd2;
      S_VIDEO:                  mode_d = 3'd1;
      S_DPRE:                   ctl_d  = 4'b0101;
      S_DGB_LEAD, S_DGB_TRAIL:  mode_d = 3'd4;
      S_DDATA:                  mode_d = 3'd3;
      default: ;
    endcase
  end

  logic [2:0] mode_q;
  logic [5:0] cd_q;
  logic       ack_q;
  logic [4:0] dic_q, pidx_q;

  always_ff @(posedge pxl_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_CTRL;
      cnt_q   <= 5'd0;
      idx_q   <= 5'd0;
      mode_q  <= 3'd0;
      cd_q    <= 6'd0;
      ack_q   <= 1'b0;
      dic_q   <= 5'd0;
      pidx_q  <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      cd_q    <= {ctl_d, vsync, hsync};
      ack_q   <= (state_d == S_DDATA) && (cnt_d == 5'd0);
      dic_q   <= (state_d == S_DDATA) ? cnt_d : 5'd0;
      pidx_q  <= idx_d;
    end
  end

  assign mode         = mode_q;
  assign control_data = cd_q;
  assign pkt_ack      = ack_q;
  assign di_cycle     = dic_q;
  assign pkt_index    = pidx_q;

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Bench for hdmi_period_scheduler: HDMI and DVI instances driven with 640x480 line timing,
// compared each cycle against a position-based model of the period schedule.
module tb_hdmi_period_scheduler;

  localparam int SSX  = 160;
  localparam int SSY  = 45;
  localparam int VP   = SSX - 10;
  localparam int DI   = 10;
  localparam int MAXP = 18;
  localparam int FW   = 800;

  logic       pxl_clk = 1'b0;
  logic       rst_n   = 1'b0;
  logic [9:0] cx = '0, cy = '0;
  logic [9:0] ssx = 10'(SSX), ssy = 10'(SSY);
  logic       hsync = 1'b0, vsync = 1'b0, pkt_valid = 1'b0;

  logic       hack, dack;
  logic [2:0] hm, dm;
  logic [5:0] hctl, dctl;
  logic [4:0] hdi, hidx, ddi, didx;

  hdmi_period_scheduler #(.DI_START_X(DI), .MAX_PACKETS(MAXP), .DVI_OUTPUT(0)) u_hdmi (
    .pxl_clk(pxl_clk), .rst_n(rst_n), .cx(cx), .cy(cy),
    .screen_start_x(ssx), .screen_start_y(ssy), .hsync(hsync), .vsync(vsync),
    .pkt_valid(pkt_valid), .pkt_ack(hack), .mode(hm), .control_data(hctl),
    .di_cycle(hdi), .pkt_index(hidx));

  hdmi_period_scheduler #(.DI_START_X(DI), .MAX_PACKETS(MAXP), .DVI_OUTPUT(1)) u_dvi (
    .pxl_clk(pxl_clk), .rst_n(rst_n), .cx(cx), .cy(cy),
    .screen_start_x(ssx), .screen_start_y(ssy), .hsync(hsync), .vsync(vsync),
    .pkt_valid(pkt_valid), .pkt_ack(dack), .mode(dm), .control_data(dctl),
    .di_cycle(ddi), .pkt_index(didx));

  always #5 pxl_clk = ~pxl_clk;

  int checks = 0;
  int errors = 0;

  // Model state: whether a video run or an island is in progress, packets granted, trail offset.
  bit m_vid, m_isl;
  int m_npk, m_trail;
  int e_mode, e_ctl4, e_ack, e_di, e_idx, e_dmode;

  // Per-line observations used by the directed checks.
  int g_acks, g_m1, g_m2, g_d1;
  int g_ack_x[$];

  task automatic model(input int x, input int y, input bit pv);
    int off, q, k, c;
    bit busy;
    e_mode = 0; e_ctl4 = 0; e_ack = 0; e_di = 0; e_idx = 0;
    busy = m_isl || m_vid;
    if (m_isl) begin
      off = x - DI;
      if (off < 8) e_ctl4 = 4'b0101;
      else if (off < 10) e_mode = 4;
      else if (m_trail >= 0) begin
        if (off - m_trail < 2) begin e_mode = 4; e_idx = m_npk - 1; end
        else m_isl = 1'b0;
      end else begin
        q = off - 10; k = q / 32; c = q % 32;
        if (c == 0 && k > 0) begin
          if (pv && k < MAXP && x + 38 <= VP) m_npk = k + 1;
          else m_trail = off;
        end
        if (m_trail >= 0) begin e_mode = 4; e_idx = m_npk - 1; end
        else begin e_mode = 3; e_di = c; e_idx = k; e_ack = (c == 0); end
      end
    end else if (m_vid) begin
      if (x < VP) m_vid = 1'b0;
      else if (x < VP + 8) e_ctl4 = 4'b0001;
      else if (x < SSX) e_mode = 2;
      else e_mode = 1;
    end
    if (!busy) begin
      if (x == VP && y >= SSY) begin m_vid = 1'b1; e_ctl4 = 4'b0001; end
      else if (x == DI && pv && DI + 48 <= VP) begin
        m_isl = 1'b1; m_npk = 1; m_trail = -1; e_ctl4 = 4'b0101;
      end
    end
    e_dmode = (x >= SSX && y >= SSY) ? 1 : 0;
  endtask

  // pvm: 0 pkt_valid low, 1 high, 2 random, 3 offered only for the first packet.
  task automatic run_line(input int y, input int x0, input int pvm, input int rst_at);
    logic [5:0] e_ctl, e_dctl;
    g_acks = 0; g_m1 = 0; g_m2 = 0; g_d1 = 0;
    g_ack_x.delete();
    cy = 10'(y);
    for (int x = x0; x < FW; x++) begin
      if (x == rst_at) begin
        rst_n = 1'b0;
        #1;
        checks++;
        if ({hm, hctl, hack, hdi, hidx} !== 20'd0) begin
          errors++;
          $display("FAIL async_reset x=%0d got mode=%0d ctl=%b ack=%b di=%0d idx=%0d want all zero",
                   x, hm, hctl, hack, hdi, hidx);
        end
        m_isl = 1'b0; m_vid = 1'b0; g_m1 = 0;
      end
      if (rst_at >= 0 && x == rst_at + 5) rst_n = 1'b1;
      cx    = 10'(x);
      hsync = 1'($urandom);
      vsync = 1'($urandom);
      case (pvm)
        0: pkt_valid = 1'b0;
        1: pkt_valid = 1'b1;
        2: pkt_valid = ($urandom_range(3) != 0);
        default: pkt_valid = (x <= 20);
      endcase
      if (rst_n) begin
        model(x, y, pkt_valid);
        e_ctl  = {4'(e_ctl4), vsync, hsync};
        e_dctl = {4'd0, vsync, hsync};
      end else begin
        e_mode = 0; e_ctl4 = 0; e_ack = 0; e_di = 0; e_idx = 0; e_dmode = 0;
        e_ctl = 6'd0; e_dctl = 6'd0;
      end
      @(posedge pxl_clk);
      #1;
      checks++;
      if (hm !== 3'(e_mode)) begin errors++;
        $display("FAIL mode y=%0d cx=%0d got %0d want %0d", y, x, hm, e_mode); end
      checks++;
      if (hctl !== e_ctl) begin errors++;
        $display("FAIL control_data y=%0d cx=%0d got %b want %b", y, x, hctl, e_ctl); end
      checks++;
      if (hack !== 1'(e_ack)) begin errors++;
        $display("FAIL pkt_ack y=%0d cx=%0d got %b want %0d", y, x, hack, e_ack); end
      checks++;
      if (hdi !== 5'(e_di)) begin errors++;
        $display("FAIL di_cycle y=%0d cx=%0d got %0d want %0d", y, x, hdi, e_di); end
      checks++;
      if (hidx !== 5'(e_idx)) begin errors++;
        $display("FAIL pkt_index y=%0d cx=%0d got %0d want %0d", y, x, hidx, e_idx); end
      checks++;
      if (dm !== 3'(e_dmode) || dctl !== e_dctl || dack !== 1'b0 || ddi !== 5'd0 || didx !== 5'd0) begin
        errors++;
        $display("FAIL dvi y=%0d cx=%0d got mode=%0d ctl=%b ack=%b want mode=%0d ctl=%b ack=0",
                 y, x, dm, dctl, dack, e_dmode, e_dctl);
      end
      if (hack === 1'b1) begin g_acks++; g_ack_x.push_back(x); end
      if (hm === 3'd1) g_m1++;
      if (hm === 3'd2) g_m2++;
      if (dm === 3'd1) g_d1++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge pxl_clk);
    #1;
    checks++;
    if ({hm, hctl, hack, hdi, hidx} !== 20'd0) begin errors++;
      $display("FAIL reset_state got mode=%0d ctl=%b ack=%b di=%0d idx=%0d want all zero",
               hm, hctl, hack, hdi, hidx); end
    rst_n = 1'b1;
    m_isl = 1'b0; m_vid = 1'b0;
    run_line(100, 0, 0, 300);
    checks++;
    if (g_m1 !== 0) begin errors++;
      $display("FAIL reset_no_video got %0d video cycles want 0", g_m1); end
    run_line(101, 0, 0, -1);
    checks++;
    if (g_m1 !== 640) begin errors++;
      $display("FAIL reset_next_line_video got %0d want 640", g_m1); end
  endtask

  task automatic test_video_line;
    run_line(SSY, 0, 0, -1);
    checks++;
    if (g_m1 !== 640 || g_m2 !== 2) begin errors++;
      $display("FAIL video_line got video=%0d guard=%0d want 640 and 2", g_m1, g_m2); end
    checks++;
    if (g_acks !== 0) begin errors++;
      $display("FAIL video_line_ack got %0d want 0", g_acks); end
  endtask

  task automatic test_island_full;
    run_line(10, 0, 1, -1);
    checks++;
    if (g_acks !== 3) begin errors++;
      $display("FAIL island_ack_count got %0d want 3", g_acks); end
    else begin
      checks++;
      if (g_ack_x[0] !== 20 || g_ack_x[1] !== 52 || g_ack_x[2] !== 84) begin errors++;
        $display("FAIL island_ack_pos got %0d/%0d/%0d want 20/52/84", g_ack_x[0], g_ack_x[1], g_ack_x[2]); end
    end
    checks++;
    if (g_m1 !== 0 || g_d1 !== 0) begin errors++;
      $display("FAIL island_blank_line got video=%0d dvi=%0d want 0", g_m1, g_d1); end
  endtask

  task automatic test_single_packet;
    run_line(200, 0, 3, -1);
    checks++;
    if (g_acks !== 1) begin errors++;
      $display("FAIL single_ack_count got %0d want 1", g_acks); end
    checks++;
    if (g_m1 !== 640 || g_d1 !== 640) begin errors++;
      $display("FAIL single_video got hdmi=%0d dvi=%0d want 640", g_m1, g_d1); end
  endtask

  task automatic test_reset_mid_island;
    run_line(20, 0, 1, 60);
    checks++;
    if (g_acks !== 2) begin errors++;
      $display("FAIL midisland_acks got %0d want 2", g_acks); end
    run_line(21, 0, 1, -1);
    checks++;
    if (g_acks !== 3) begin errors++;
      $display("FAIL midisland_restart got %0d want 3", g_acks); end
  endtask

  task automatic test_random_lines;
    int y;
    for (int n = 0; n < 28; n++) begin
      y = $urandom_range(524);
      run_line(y, 0, $urandom_range(2), -1);
    end
  endtask

  initial begin
    test_reset();
    test_video_line();
    test_island_full();
    test_single_packet();
    test_reset_mid_island();
    test_random_lines();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
